// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control constants: opcodes, FSM state codes, aluOp codes and
// the decoded select bundle used by the multi-cycle and single-cycle units.
package mips_ctrl_pkg;

  localparam int OPC_W = 6;

  localparam logic [OPC_W-1:0] OP_R    = 6'b000000;
  localparam logic [OPC_W-1:0] OP_J    = 6'b000010;
  localparam logic [OPC_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OPC_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OPC_W-1:0] OP_ANDI = 6'b001100;
  localparam logic [OPC_W-1:0] OP_ORI  = 6'b001101;
  localparam logic [OPC_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OPC_W-1:0] OP_HALT = 6'b111111;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_IMM   = 2'b11
  } aluop_e;

  typedef enum logic [3:0] {
    C_R, C_LW, C_SW, C_BEQ, C_ORI, C_ANDI, C_ADDI, C_J, C_HALT, C_ILL
  } op_class_e;

  typedef struct packed {
    aluop_e alu_op;
    logic   reg_dst;
    logic   mem_to_reg;
    logic   alu_src;
    logic   ext_sel;
  } sel_t;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode decoder: classifies the opcode and produces the
// datapath selects that stay constant for the life of an instruction.
module op_decode
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] i_op,
  output op_class_e       o_class,
  output sel_t            o_sel
);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    o_class = C_ILL;
    o_sel   = '0;
    case (i_op)
      OP_W'(OP_R): begin
        o_class          = C_R;
        o_sel.alu_op     = ALU_RTYPE;
        o_sel.reg_dst    = 1'b1;
        o_sel.mem_to_reg = 1'b1;
      end
      OP_W'(OP_LW): begin
        o_class       = C_LW;
        o_sel.alu_op  = ALU_ADD;
        o_sel.alu_src = 1'b1;
      end
      OP_W'(OP_SW): begin
        o_class       = C_SW;
        o_sel.alu_op  = ALU_ADD;
        o_sel.alu_src = 1'b1;
      end
      OP_W'(OP_BEQ): begin
        o_class      = C_BEQ;
        o_sel.alu_op = ALU_SUB;
      end
      OP_W'(OP_ORI): begin
        o_class       = C_ORI;
        o_sel.alu_op  = ALU_IMM;
        o_sel.alu_src = 1'b1;
        o_sel.ext_sel = 1'b1;
      end
      OP_W'(OP_ANDI): begin
        o_class       = C_ANDI;
        o_sel.alu_op  = ALU_IMM;
        o_sel.alu_src = 1'b1;
        o_sel.ext_sel = 1'b1;
      end
      OP_W'(OP_ADDI): begin
        o_class       = C_ADDI;
        o_sel.alu_op  = ALU_IMM;
        o_sel.alu_src = 1'b1;
      end
      OP_W'(OP_J):    o_class = C_J;
      OP_W'(OP_HALT): o_class = C_HALT;
      default:        o_class = C_ILL;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control unit: IF/ID/EXE/MEM/WB/HALT sequencer with
// state-decoded strobes and a saturating retired-instruction counter.
module multi_cycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W          = 6,
  parameter int ALUOP_W       = 2,
  parameter int CNT_W         = 32,
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  input  logic               memReady,
  output logic [ALUOP_W-1:0] aluOp,
  output logic               regDst,
  output logic               jump,
  output logic               branch,
  output logic               branchTaken,
  output logic               memRead,
  output logic               memWrite,
  output logic               memToReg,
  output logic               aluSrc,
  output logic               regWrite,
  output logic               extSel,
  output logic               PCWre,
  output logic               IRWre,
  output logic               illegalOp,
  output logic               halted,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   instrCount
);

  state_e           r_state;
  logic [CNT_W-1:0] r_count;
  op_class_e        w_class;
  sel_t             w_sel;
  logic             w_mem_ready;

  assign w_mem_ready = USE_MEM_READY ? memReady : 1'b1;

  op_decode #(.OP_W(OP_W)) u_op_decode (
    .i_op    (op),
    .o_class (w_class),
    .o_sel   (w_sel)
  );

  // Selects follow the opcode directly; op is stable from ID through WB.
  assign aluOp      = ALUOP_W'(w_sel.alu_op);
  assign regDst     = w_sel.reg_dst;
  assign memToReg   = w_sel.mem_to_reg;
  assign aluSrc     = w_sel.alu_src;
  assign extSel     = w_sel.ext_sel;
  assign state      = r_state;
  assign instrCount = r_count;
  assign halted     = (r_state == S_HALT);

  always_comb begin
    IRWre       = 1'b0;
    PCWre       = 1'b0;
    regWrite    = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    branch      = 1'b0;
    branchTaken = 1'b0;
    jump        = 1'b0;
    illegalOp   = 1'b0;
    case (r_state)
      S_IF: IRWre = 1'b1;
      S_ID: begin
        if (w_class == C_J) begin
          jump  = 1'b1;
          PCWre = 1'b1;
        end else if (w_class == C_ILL) begin
          illegalOp = 1'b1;
          PCWre     = 1'b1;
        end
      end
      S_EXE: begin
        if (w_class == C_BEQ) begin
          branch      = 1'b1;
          PCWre       = 1'b1;
          branchTaken = zero;
        end
      end
      S_MEM: begin
        memRead  = (w_class == C_LW);
        memWrite = (w_class == C_SW);
        // sw retires from MEM; lw retires later in WB.
        PCWre    = (w_class == C_SW) && w_mem_ready;
      end
      S_WB: begin
        regWrite = 1'b1;
        PCWre    = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IF;
      r_count <= '0;
    end else begin
      if (PCWre && (r_count != {CNT_W{1'b1}})) begin
        r_count <= r_count + CNT_W'(1);
      end
      case (r_state)
        S_IF: r_state <= S_ID;
        S_ID: begin
          case (w_class)
            C_HALT:     r_state <= S_HALT;
            C_J, C_ILL: r_state <= S_IF;
            default:    r_state <= S_EXE;
          endcase
        end
        S_EXE: begin
          case (w_class)
            C_LW, C_SW:                   r_state <= S_MEM;
            C_R, C_ORI, C_ANDI, C_ADDI:   r_state <= S_WB;
            default:                      r_state <= S_IF;
          endcase
        end
        S_MEM: begin
          if (w_class != C_LW && w_class != C_SW) begin
            r_state <= S_IF;
          end else if (w_mem_ready) begin
            r_state <= (w_class == C_LW) ? S_WB : S_IF;
          end
        end
        S_WB:    r_state <= S_IF;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: per-op sequencing, latencies,
// memory wait, branch outcome, illegal/halt handling, reset and saturation.
module tb_multi_cycle_control;

  logic        clk = 1'b0;
  logic        reset, zero, memReady;
  logic [5:0]  op;
  logic [1:0]  aluOp;
  logic        regDst, jump, branch, branchTaken, memRead, memWrite, memToReg;
  logic        aluSrc, regWrite, extSel, PCWre, IRWre, illegalOp, halted;
  logic [2:0]  state;
  logic [31:0] instrCount;

  logic        r4_reset;
  logic [5:0]  r4_op;
  logic [1:0]  r4_aluOp;
  logic        r4_regDst, r4_jump, r4_branch, r4_branchTaken, r4_memRead;
  logic        r4_memWrite, r4_memToReg, r4_aluSrc, r4_regWrite, r4_extSel;
  logic        r4_PCWre, r4_IRWre, r4_illegalOp, r4_halted;
  logic [2:0]  r4_state;
  logic [3:0]  r4_instrCount;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_cycle_control dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .memReady(memReady),
    .aluOp(aluOp), .regDst(regDst), .jump(jump), .branch(branch),
    .branchTaken(branchTaken), .memRead(memRead), .memWrite(memWrite),
    .memToReg(memToReg), .aluSrc(aluSrc), .regWrite(regWrite), .extSel(extSel),
    .PCWre(PCWre), .IRWre(IRWre), .illegalOp(illegalOp), .halted(halted),
    .state(state), .instrCount(instrCount)
  );

  multi_cycle_control #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(r4_reset), .op(r4_op), .zero(1'b0), .memReady(1'b1),
    .aluOp(r4_aluOp), .regDst(r4_regDst), .jump(r4_jump), .branch(r4_branch),
    .branchTaken(r4_branchTaken), .memRead(r4_memRead), .memWrite(r4_memWrite),
    .memToReg(r4_memToReg), .aluSrc(r4_aluSrc), .regWrite(r4_regWrite),
    .extSel(r4_extSel), .PCWre(r4_PCWre), .IRWre(r4_IRWre),
    .illegalOp(r4_illegalOp), .halted(r4_halted), .state(r4_state),
    .instrCount(r4_instrCount)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  function automatic logic [9:0] strobes();
    return {IRWre, PCWre, regWrite, memRead, memWrite, branch, jump,
            illegalOp, branchTaken, halted};
  endfunction

  // Runs one instruction from IF until the cycle that asserts PCWre.
  // zero is driven inverted outside EXE so a stray sample would be visible.
  task automatic run_instr(input logic [5:0] op_v, input logic zero_v, input int waits,
                           output int cyc, output int mem_cyc, output logic bt,
                           output int ill_cnt, output int rw_cnt,
                           output int mrd_cnt, output int mwr_cnt);
    bit done;
    done = 0; cyc = 0; mem_cyc = 0; bt = 1'bx;
    ill_cnt = 0; rw_cnt = 0; mrd_cnt = 0; mwr_cnt = 0;
    op = op_v;
    while (!done && cyc < 30) begin
      cyc++;
      zero = (state == 3'd2) ? zero_v : ~zero_v;
      if (state == 3'd3) begin
        mem_cyc++;
        memReady = (mem_cyc > waits);
      end else begin
        memReady = 1'b0;
      end
      #1;
      if (illegalOp) ill_cnt++;
      if (regWrite)  rw_cnt++;
      if (memRead)   mrd_cnt++;
      if (memWrite)  mwr_cnt++;
      if (PCWre) begin
        bt   = branchTaken;
        done = 1;
      end
      tick();
    end
    memReady = 1'b0;
    if (!done) check("instr_timeout", 32'(cyc), 32'd0);
  endtask

  logic [5:0] sel_ops [9];
  logic [5:0] sel_exp [9];

  initial begin
    int   cyc, mem_cyc, ill, rw, mrd, mwr, halt_cyc, pc_pulses, pulses;
    logic bt;

    reset = 1'b1; op = 6'b000000; zero = 1'b0; memReady = 1'b0;
    r4_reset = 1'b1; r4_op = 6'b000010;
    tick(); tick();
    #1;

    check("reset_state", 32'(state), 32'd0);
    check("reset_strobes", 32'(strobes()), 32'b1000000000);
    check("reset_count", instrCount, 32'd0);

    // Select table: {aluOp, regDst, memToReg, aluSrc, extSel}, checked in reset.
    sel_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001101,
                6'b001100, 6'b001000, 6'b000010, 6'b010101};
    sel_exp = '{6'b101100, 6'b000010, 6'b000010, 6'b010000, 6'b110011,
                6'b110011, 6'b110010, 6'b000000, 6'b000000};
    for (int i = 0; i < 9; i++) begin
      op = sel_ops[i];
      #1;
      check($sformatf("sel_op%02h", sel_ops[i]),
            32'({aluOp, regDst, memToReg, aluSrc, extSel}), 32'(sel_exp[i]));
    end

    // R-type walked state by state.
    op = 6'b000000;
    reset = 1'b0;
    #1;
    check("r_if_state", 32'(state), 32'd0);
    tick();
    check("r_id", 32'({state, PCWre, regWrite}), {27'd0, 3'd1, 2'b00});
    tick();
    check("r_exe", 32'({state, PCWre, regWrite}), {27'd0, 3'd2, 2'b00});
    tick();
    check("r_wb", 32'({state, PCWre, regWrite}), {27'd0, 3'd4, 2'b11});
    tick();
    check("r_back_if", 32'({state, IRWre}), {28'd0, 3'd0, 1'b1});
    check("r_count", instrCount, 32'd1);

    // lw with three not-ready MEM cycles.
    run_instr(6'b100011, 1'b0, 3, cyc, mem_cyc, bt, ill, rw, mrd, mwr);
    check("lw_latency", 32'(cyc), 32'd8);
    check("lw_mem_cycles", 32'(mem_cyc), 32'd4);
    check("lw_memread_cycles", 32'(mrd), 32'd4);
    check("lw_regwrite", 32'(rw), 32'd1);
    check("lw_count", instrCount, 32'd2);

    // sw without wait, then j.
    run_instr(6'b101011, 1'b0, 0, cyc, mem_cyc, bt, ill, rw, mrd, mwr);
    check("sw_latency", 32'(cyc), 32'd4);
    check("sw_memwrite", 32'({mwr[3:0], rw[3:0]}), 32'h10);
    run_instr(6'b000010, 1'b0, 0, cyc, mem_cyc, bt, ill, rw, mrd, mwr);
    check("j_latency", 32'(cyc), 32'd2);
    check("j_count", instrCount, 32'd4);

    // beq pair from a fresh reset.
    do_reset();
    run_instr(6'b000100, 1'b1, 0, cyc, mem_cyc, bt, ill, rw, mrd, mwr);
    check("beq_z1_taken", 32'(bt), 32'd1);
    run_instr(6'b000100, 1'b0, 0, cyc, mem_cyc, bt, ill, rw, mrd, mwr);
    check("beq_z0_taken", 32'(bt), 32'd0);
    check("beq_count", instrCount, 32'd2);

    // Illegal opcode executes as a NOP.
    run_instr(6'b010101, 1'b0, 0, cyc, mem_cyc, bt, ill, rw, mrd, mwr);
    check("ill_pulses", 32'(ill), 32'd1);
    check("ill_latency", 32'(cyc), 32'd2);
    check("ill_back_if", 32'(state), 32'd0);
    check("ill_count", instrCount, 32'd3);

    // Halt: IF, ID, then HALT held.
    op = 6'b111111;
    tick(); tick();
    halt_cyc = 0; pc_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (halted && state == 3'd5 && strobes() == 10'b0000000001) halt_cyc++;
      if (PCWre) pc_pulses++;
      tick();
    end
    check("halt_held", 32'(halt_cyc), 32'd10);
    check("halt_no_pcwre", 32'(pc_pulses), 32'd0);
    check("halt_count", instrCount, 32'd3);

    // Reset out of HALT, then reset during sw MEM wait.
    do_reset();
    check("halt_reset_state", 32'(state), 32'd0);
    op = 6'b101011; memReady = 1'b0;
    tick(); tick(); tick(); tick();
    check("sw_wait_mem", 32'({state, memWrite}), {28'd0, 3'd3, 1'b1});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("sw_rst_state", 32'(state), 32'd0);
    check("sw_rst_strobes", 32'(strobes()), 32'b1000000000);
    check("sw_rst_count", instrCount, 32'd0);

    // Narrow counter saturation with back-to-back j.
    r4_reset = 1'b0;
    #1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (r4_PCWre) pulses++;
      tick();
      if (pulses == 14 && r4_PCWre == 1'b0 && r4_state == 3'd0)
        check("cnt4_at14", 32'(r4_instrCount), 32'd14);
    end
    check("cnt4_retired", 32'(pulses), 32'd20);
    check("cnt4_saturated", 32'(r4_instrCount), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
